// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared types and constants for the 5-stage pipeline hazard controller.
//   fwd_sel_t        : operand source select driven onto ForwardAE/ForwardBE.
//   mem_wait_state_t : states of the data-memory wait FSM.
//   REG_PC           : architectural PC register number (never forwarded).
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,   // register file value
      FWD_WB  = 2'b01,   // writeback result
      FWD_MEM = 2'b10    // ALUOutM
   } fwd_sel_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WAIT    = 2'b01,
      RELEASE = 2'b10
   } mem_wait_state_t;

   localparam logic [3:0] REG_PC = 4'hF;

   // A later stage can supply an operand when it writes a matching,
   // non-PC destination register.
   function automatic logic fwd_match(input logic       we,
                                      input logic [3:0] wa,
                                      input logic [3:0] ra);
      return we && (wa == ra) && (wa != REG_PC);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// pipe_fwd_sel
//   Forward-select for one execute-stage source operand. The M stage wins
//   over the W stage because it holds the younger result.
//   Ports:
//     ra_e        in  4  execute-stage source register
//     wa3_m/_w    in  4  destination registers in M and W
//     reg_write_m in  1  M-stage register-write enable
//     reg_write_w in  1  W-stage register-write enable
//     fwd_sel     out 2  FWD_MEM / FWD_WB / FWD_RF
module pipe_fwd_sel
   import pipe_ctrl_pkg::*;
(
   input  logic [3:0] ra_e,
   input  logic [3:0] wa3_m,
   input  logic [3:0] wa3_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output fwd_sel_t   fwd_sel
);

   always_comb begin
      fwd_sel = FWD_RF;
      if (fwd_match(reg_write_m, wa3_m, ra_e))
         fwd_sel = FWD_MEM;
      else if (fwd_match(reg_write_w, wa3_w, ra_e))
         fwd_sel = FWD_WB;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage ARM pipeline: operand
//   forwarding, load-use stalls, PC-write flushes and variable-latency
//   data-memory waits guarded by a timeout so a hung memory cannot freeze
//   the core.
//   Ports:
//     clk, reset                 clock; synchronous active-low reset
//     RA1D/RA2D, RA1E/RA2E       source registers in D and E
//     WA3E/WA3M/WA3W             destination registers in E, M, W
//     RegWriteE/M/W, MemToRegE   write enables, load-in-E flag
//     PCSrcD/E/M/W, BranchTakenE PC-write tracking, taken branch in E
//     MemReqM, MemReadyM         data-memory request / completion in M
//     ForwardAE/BE               operand source select (00 RF, 01 WB, 10 M)
//     StallF/D/E/M               hold pipeline registers
//     FlushD/E/W                 load bubbles into pipeline registers
//     MemTimeout                 one-cycle pulse when a wait is forced off
//   Optional build macro HAZARD_PERF_EN adds saturating performance
//   counters LduCnt, MemWaitCnt and FlushCnt (CNT_W bits each).
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       RA1D,
   input  logic [3:0]       RA2D,
   input  logic [3:0]       RA1E,
   input  logic [3:0]       RA2E,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       WA3M,
   input  logic [3:0]       WA3W,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemToRegE,
   input  logic             PCSrcD,
   input  logic             PCSrcE,
   input  logic             PCSrcM,
   input  logic             PCSrcW,
   input  logic             BranchTakenE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
`ifdef HAZARD_PERF_EN
   output logic [CNT_W-1:0] LduCnt,
   output logic [CNT_W-1:0] MemWaitCnt,
   output logic [CNT_W-1:0] FlushCnt,
`endif
   output logic             MemTimeout
);

   // Counter value in the last permitted wait cycle.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   mem_wait_state_t state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            mem_timeout_q, mem_timeout_d;

   logic     wait_req, to_hit, mem_stall, ldr_stall, pc_pend;
   fwd_sel_t fwd_a, fwd_b;

   // ---------------------------------------------------------------- forwarding
   pipe_fwd_sel u_fwd_a (
      .ra_e        (RA1E),
      .wa3_m       (WA3M),
      .wa3_w       (WA3W),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd_sel     (fwd_a)
   );

   pipe_fwd_sel u_fwd_b (
      .ra_e        (RA2E),
      .wa3_m       (WA3M),
      .wa3_w       (WA3W),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd_sel     (fwd_b)
   );

   // ---------------------------------------------------------------- hazards
   assign ldr_stall = MemToRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
   assign pc_pend   = PCSrcD || PCSrcE || PCSrcM;
   assign wait_req  = MemReqM && !MemReadyM;
   assign to_hit    = (state_q == WAIT) && (cnt_q == TO_LAST);
   // RELEASE masks the stall for one cycle so the stuck access retires.
   assign mem_stall = wait_req && !to_hit && (state_q != RELEASE);

   // ---------------------------------------------------------------- wait FSM
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wait_req) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            // Completion wins over timeout in the same cycle. A withdrawn
            // request also ends the wait so no spurious timeout is raised.
            if (MemReadyM || !MemReqM) begin
               state_d = IDLE;
            end else if (to_hit) begin
               state_d       = RELEASE;
               mem_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign MemTimeout = mem_timeout_q;

   // ---------------------------------------------------------------- controls
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (!reset) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else begin
         ForwardAE = fwd_a;
         ForwardBE = fwd_b;
         if (mem_stall) begin
            // Whole pipe frozen; a taken branch stays in E and flushes once
            // the stall drops. W takes a bubble to avoid a repeated write.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else begin
            StallF = ldr_stall || pc_pend;
            StallD = ldr_stall;
            FlushD = pc_pend || PCSrcW || BranchTakenE;
            FlushE = ldr_stall || BranchTakenE;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   // ---------------------------------------------------------------- perf
   logic [CNT_W-1:0] ldu_cnt_q, ldu_cnt_d;
   logic [CNT_W-1:0] mem_wait_cnt_q, mem_wait_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic             en);
      return (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
   endfunction

   always_comb begin
      ldu_cnt_d      = sat_inc(ldu_cnt_q, ldr_stall);
      mem_wait_cnt_d = sat_inc(mem_wait_cnt_q, mem_stall);
      flush_cnt_d    = sat_inc(flush_cnt_q, FlushD || FlushE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ldu_cnt_q      <= '0;
         mem_wait_cnt_q <= '0;
         flush_cnt_q    <= '0;
      end else begin
         ldu_cnt_q      <= ldu_cnt_d;
         mem_wait_cnt_q <= mem_wait_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
      end
   end

   assign LduCnt     = ldu_cnt_q;
   assign MemWaitCnt = mem_wait_cnt_q;
   assign FlushCnt   = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE;
   logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
   logic       MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
`ifdef HAZARD_PERF_EN
   logic [15:0] LduCnt, MemWaitCnt, FlushCnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard of expected control vectors:
   // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE, MemTimeout}
   logic [11:0] sb[$];
   logic [11:0] ctl;
   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                 ForwardAE, ForwardBE, MemTimeout};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .TO_W(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemToRegE(MemToRegE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
`ifdef HAZARD_PERF_EN
      .LduCnt(LduCnt), .MemWaitCnt(MemWaitCnt), .FlushCnt(FlushCnt),
`endif
      .MemTimeout(MemTimeout)
   );

   function automatic logic [11:0] mk(input logic [3:0] st, input logic [2:0] fl,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic to);
      return {st, fl, fa, fb, to};
   endfunction

   task automatic set_idle();
      RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
      WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemToRegE = 1'b0;
      PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
      BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
   endtask

   // Inputs are applied just after a rising edge.
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic sample(output logic [11:0] g);
      @(negedge clk);
      g = ctl;
   endtask

   task automatic test_reset();
      logic [11:0] got, want;
      reset = 1'b0;
      set_idle();
      // Would forward / stall if reset did not override.
      RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
      MemReqM = 1'b1; PCSrcD = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         sb.push_back(mk(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0));
         sample(got);
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL reset[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_forward();
      logic [11:0] got, want;
      logic [3:0] ra1[4] = '{4'd3, 4'd3, 4'd15, 4'd4};
      logic [3:0] ra2[4] = '{4'd7, 4'd3, 4'd15, 4'd9};
      logic [3:0] wm[4]  = '{4'd3, 4'd3, 4'd15, 4'd9};
      logic [3:0] ww[4]  = '{4'd3, 4'd3, 4'd15, 4'd4};
      logic       rm[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] ea[4]  = '{2'b10, 2'b01, 2'b00, 2'b01};
      logic [1:0] eb[4]  = '{2'b00, 2'b01, 2'b00, 2'b10};
      for (int i = 0; i < 4; i++) begin
         tick();
         set_idle();
         RA1E = ra1[i]; RA2E = ra2[i]; WA3M = wm[i]; WA3W = ww[i];
         RegWriteM = rm[i]; RegWriteW = 1'b1;
         sb.push_back(mk(4'b0000, 3'b000, ea[i], eb[i], 1'b0));
         sample(got);
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL forward[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_load_use();
      logic [11:0] got, want;
      for (int i = 0; i < 5; i++) begin
         tick();
         set_idle();
         WA3E = 4'd5; RA1D = 4'd1; RA2D = 4'd5;
         case (i)
            0: begin MemToRegE = 1'b1; RegWriteE = 1'b1; end
            1: ;                                               // load moved on
            2: begin MemToRegE = 1'b1; RegWriteE = 1'b1; RA1D = 4'd5; RA2D = 4'd0; end
            3: MemToRegE = 1'b1;                               // no write
            default: RegWriteE = 1'b1;                         // ALU op, not load
         endcase
         sb.push_back((i == 0 || i == 2) ? mk(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0)
                                         : mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
         sample(got);
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL load_use[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_branch();
      logic [11:0] got, want;
      logic [11:0] exp_tbl[8];
      exp_tbl = '{mk(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0),   // taken branch
                  mk(4'b1000, 3'b100, 2'b00, 2'b00, 1'b0),   // PCSrcD
                  mk(4'b1000, 3'b100, 2'b00, 2'b00, 1'b0),   // PCSrcE
                  mk(4'b1000, 3'b100, 2'b00, 2'b00, 1'b0),   // PCSrcM
                  mk(4'b0000, 3'b100, 2'b00, 2'b00, 1'b0),   // PCSrcW
                  mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0),   // passed
                  mk(4'b1100, 3'b110, 2'b00, 2'b00, 1'b0),   // load-use + pc_pend
                  mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0)};
      for (int i = 0; i < 8; i++) begin
         tick();
         set_idle();
         case (i)
            0: BranchTakenE = 1'b1;
            1: PCSrcD = 1'b1;
            2: PCSrcE = 1'b1;
            3: PCSrcM = 1'b1;
            4: PCSrcW = 1'b1;
            6: begin
               MemToRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
               RA2D = 4'd9; PCSrcE = 1'b1;
            end
            default: ;
         endcase
         sb.push_back(exp_tbl[i]);
         sample(got);
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL branch[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_mem_wait();
      logic [11:0] got, want;
      for (int i = 0; i < 6; i++) begin
         tick();
         set_idle();
         if (i < 5) begin
            MemReqM = 1'b1; BranchTakenE = 1'b1;     // branch deferred by stall
            MemReadyM = (i == 4);
         end
         if (i < 4)       sb.push_back(mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
         else if (i == 4) sb.push_back(mk(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0));
         else             sb.push_back(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
         sample(got);
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL mem_wait[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_timeout();
      logic [11:0] got, want;
      logic st, to;
      for (int i = 0; i < 14; i++) begin
         tick();
         set_idle();
         if (i < 13) begin
            MemReqM = 1'b1;
            MemReadyM = (i == 12);
         end
         // 8 stall cycles, to_hit cycle, RELEASE (pulse), then stall again.
         st = (i < 8) || (i == 10) || (i == 11);
         to = (i == 9);
         sb.push_back(mk({4{st}}, {2'b00, st}, 2'b00, 2'b00, to));
         sample(got);
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL timeout[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [11:0] got, want;
      logic st;
      for (int i = 0; i < 15; i++) begin
         tick();
         set_idle();
         reset = (i != 3);
         MemReqM = (i < 13);
         st = (i < 3) || (i >= 4 && i <= 11);
         if (i == 3)       sb.push_back(mk(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0));
         else if (i == 13) sb.push_back(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1));
         else              sb.push_back(mk({4{st}}, {2'b00, st}, 2'b00, 2'b00, 1'b0));
         sample(got);
         want = sb.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL reset_mid_wait[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   initial begin
      set_idle();
      reset = 1'b0;
      test_reset();
      tick();
      set_idle();
      reset = 1'b1;
      test_forward();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage ARM pipeline.
- Drives stall, flush and forwarding controls for the F/D, D/E, E/M and M/W pipeline registers.
- Resolves load-use hazards, PC-write (branch) hazards, and variable-latency data-memory waits, for example when a camera frame-buffer access is slow.
- Contains a wait FSM with a timeout counter so a hung memory cannot freeze the core indefinitely.

Parameters:
- MEM_TIMEOUT, 255: maximum number of consecutive mem-wait cycles before a forced release.
- TO_W, 8: width of the timeout counter; requires MEM_TIMEOUT < 2**TO_W.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- RA1D, RA2D  in  4  decode-stage source registers.
- RA1E, RA2E  in  4  execute-stage source registers.
- WA3E, WA3M, WA3W  in  4  destination registers in E, M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
- MemToRegE  in  1  the instruction in E is a load.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  an instruction in that stage writes the PC.
- BranchTakenE  in  1  branch resolved taken in E.
- MemReqM  in  1  the instruction in M accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2  operand source: 00 regfile, 01 WB result, 10 ALUOutM.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  load a bubble into the corresponding register.
- MemTimeout  out  1  one-cycle pulse when a wait is forcibly ended.

Behaviour:
- Reset (reset==0 at a rising edge):
  - FSM goes to IDLE, timeout counter to 0, MemTimeout to 0.
  - While reset is low, outputs are: Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && WA3M==RA1E && WA3M!=4'hF.
  - Otherwise ForwardAE=01 if RegWriteW && WA3W==RA1E && WA3W!=4'hF.
  - Otherwise ForwardAE=00.
  - M has priority over W. ForwardBE is identical, using RA2E.
  - R15 (PC) is never forwarded.
- Load-use hazard:
  - ldr_stall = MemToRegE && RegWriteE && (WA3E==RA1D || WA3E==RA2D).
- PC-write hazard:
  - pc_pend = PCSrcD || PCSrcE || PCSrcM.
- Memory wait:
  - mem_stall = MemReqM && !MemReadyM && !to_hit.
  - to_hit is asserted in WAIT when the counter equals MEM_TIMEOUT-1.
- Controls when mem_stall==0:
  - StallF = ldr_stall || pc_pend.
  - StallD = ldr_stall.
  - FlushD = pc_pend || PCSrcW || BranchTakenE.
  - FlushE = ldr_stall || BranchTakenE.
  - StallE = StallM = FlushW = 0.
- Controls when mem_stall==1 (overrides everything above):
  - StallF = StallD = StallE = StallM = 1.
  - FlushD = FlushE = 0.
  - FlushW = 1, so the M/W register captures a bubble and no duplicate writeback occurs.
- Wait FSM states: IDLE, WAIT, RELEASE.
  - IDLE: if MemReqM && !MemReadyM, go to WAIT with counter=0.
  - WAIT, MemReadyM==1: go to IDLE. The stall drops in this same cycle (zero-cycle release).
  - WAIT, to_hit: go to RELEASE and pulse MemTimeout=1 on that transition edge. The stall drops in the to_hit cycle.
  - WAIT, otherwise: counter increments.
  - RELEASE: lasts one cycle, with the stall masked even if MemReqM && !MemReadyM. Then go to IDLE. This guarantees forward progress.
- Latency: every stall, flush and forward output is a combinational function of the inputs plus the registered FSM state. Zero cycles of added latency.
- Simultaneous events:
  - mem_stall together with BranchTakenE: the flush is deferred. The branch stays in E, so the flush asserts in the cycle the stall drops.
  - ldr_stall together with pc_pend: both apply.
- Reset during WAIT: the FSM returns to IDLE immediately and the counter clears. No MemTimeout pulse.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs LduCnt, MemWaitCnt and FlushCnt, each [CNT_W-1:0].
  - These count cycles with ldr_stall, cycles with mem_stall, and cycles with FlushD||FlushE.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the ports and logic are absent. All other behaviour is unchanged.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - mem_wait_state_t enum: IDLE, WAIT, RELEASE.
  - Constant REG_PC=4'hF.
- Sub-module pipe_fwd_sel: per-operand forward-select logic, instantiated twice (operands A and B).

Test Plan:
- Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. RA1E=WA3M=15 -> ForwardAE=00.
- Load-use: MemToRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle, FlushD=0.
- Branch: BranchTakenE=1 -> FlushD=FlushE=1. PCSrcD=1 -> StallF=FlushD=1 until PCSrcW has passed.
- Memory wait: MemReqM=1 with MemReadyM low for 4 cycles -> StallF/D/E/M=1 and FlushW=1 for 4 cycles; cleared in the cycle MemReadyM=1; MemTimeout stays 0.
- Timeout: MEM_TIMEOUT=8, MemReadyM held 0 -> stall for 8 cycles, MemTimeout pulses once, 1 RELEASE cycle with no stall, then the stall re-asserts.
- Reset mid-wait: reset=0 in WAIT cycle 3 -> next cycle: IDLE, all Stall*=0, FlushD/E/W=1, no MemTimeout pulse.
